div3_seq_ctrl: RTL and testbench
================================

// Module: div3_seq_ctrl
// PURPOSE
//  Sequencer for a wide divisible-by-3 check. Accepts one WIDTH-bit operand over valid/ready.
//  Walks the operand LSB-first in CHUNK-bit slices through one shared chunk-residue unit,
//  one slice per clock, and accumulates the mod-3 residue.
//  Returns residue + divisible flag over valid/ready. Ends early once the remaining bits are zero.
// PARAMETERS
//  WIDTH  32  operand width; must be a multiple of CHUNK
//  CHUNK   8  bits consumed per cycle; even, >=2 (so 2^CHUNK = 1 mod 3 and slice weights vanish)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operand offered
//  in_ready   out  1      block can accept an operand
//  in_data    in   WIDTH  operand, unsigned
//  out_valid  out  1      result available
//  out_ready  in   1      consumer takes result
//  out_rem    out  2      operand mod 3 (0..2)
//  out_div    out  1      1 when out_rem == 0
//  busy       out  1      state != IDLE
// BEHAVIOUR
//  - Reset (rst=1 at an edge): state=IDLE; acc=0; cnt=0; shreg=0; out_valid=0; out_rem=0; out_div=0.
//    in_ready=0 while rst=1. Any operation in flight, including a pending result, is dropped.
//  - FSM IDLE -> RUN -> DONE -> IDLE.
//    in_ready = (state==IDLE) & !rst. out_valid = (state==DONE).
//  - IDLE: on in_valid&in_ready: shreg<=in_data, acc<=0, cnt<=0, go RUN.
//    No overlap between operands; a second operand waits until IDLE.
//  - RUN, each cycle:
//      r_c  = chunk residue of shreg[CHUNK-1:0]
//      acc <= (acc + r_c) mod 3
//      shreg <= shreg >> CHUNK
//      cnt <= cnt+1
//    Go to DONE when cnt==NCHUNK-1 OR (shreg>>CHUNK)==0.
//  - Chunk residue: E = popcount of even bit positions, O = popcount of odd bit positions
//    in the slice; r_c = (E + 2*O) mod 3. No signed arithmetic.
//    Intermediate width: $clog2(CHUNK)+2 bits; no overflow permitted.
//  - Latency: k = index of highest nonzero slice + 1 (k=1 for a zero operand), 1 <= k <= NCHUNK.
//    out_valid rises k cycles after the accept edge.
//  - DONE: out_rem=acc, out_div=(acc==0). Both held stable while out_valid=1 and out_ready=0.
//    On out_valid&out_ready go IDLE; in_ready=1 on the next cycle.
//    Minimum operand-to-operand spacing is k+2 cycles.
//  - out_ready is ignored outside DONE. in_valid is ignored outside IDLE.
//    in_data is sampled only at the accept edge.
// STRUCTURE
//  - Shared package div3_pkg:
//      state localparams IDLE=2'd0, RUN=2'd1, DONE=2'd2
//      function NCHUNK(WIDTH,CHUNK) = WIDTH/CHUNK
//      CNT_W = max(1, $clog2(NCHUNK))
//      function mod3_add(a,b) on 2-bit values
//  - Sub-module div3_chunk_res #(CHUNK): combinational slice -> 2-bit r_c, built from
//    alternating even/odd popcounts. One instance is shared by all slices.
//  - Elaboration check: WIDTH%CHUNK!=0 or CHUNK odd -> $error.
// TESTING (WIDTH=32, CHUNK=8, out_ready=1 unless stated)
//  1. in_data=0x00000000 -> out_rem=0, out_div=1, out_valid 1 cycle after accept (k=1).
//  2. in_data=0x00010000 -> out_rem=1, out_div=0, k=3.
//     in_data=0x80000000 -> out_rem=2, k=4.
//  3. in_data=0xFFFFFFFF -> out_rem=0, out_div=1, k=4.
//     in_data=0x00000003 -> out_rem=0, k=1.
//  4. Backpressure on 0x00000007: hold out_ready=0 for 5 cycles ->
//     out_valid=1, out_rem=1 stable; in_ready=0 throughout; IDLE one cycle after out_ready=1.
//  5. Load 0xFFFFFFFF, assert rst on the 2nd RUN cycle ->
//     next cycle state=IDLE, out_valid=0, acc=0; a following 0x00000005 gives out_rem=2.
//  6. Hold in_valid=1 with 200 random operands back-to-back ->
//     each out_rem equals the model value (operand % 3), each k matches the slice count,
//     and no operand is lost or duplicated.

Source files
------------

// File: rtl/div3_pkg.sv
// Shared definitions for the divisible-by-3 sequencer.
//  - state_t   : sequencer FSM states
//  - NCHUNK    : number of CHUNK-bit slices in a WIDTH-bit operand
//  - CNT_W     : slice counter width, at least 1 bit
//  - mod3_add  : sum of two residues (0..2) reduced mod 3
package div3_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int NCHUNK(input int width, input int chunk);
    return width / chunk;
  endfunction

  function automatic int CNT_W(input int nchunk);
    return (nchunk <= 1) ? 1 : $clog2(nchunk);
  endfunction

  function automatic logic [1:0] mod3_add(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

endpackage

// File: rtl/div3_chunk_res.sv
// Combinational residue of one CHUNK-bit slice modulo 3.
// Bit weights 2^i mod 3 alternate 1,2,1,2,... so the residue is
// (popcount(even bits) + 2*popcount(odd bits)) mod 3.
// Ports:
//  slice  in   CHUNK  slice value, unsigned
//  r_c    out  2      slice mod 3 (0..2)
module div3_chunk_res #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] slice,
  output logic [1:0]       r_c
);

  // Largest sum is 3*CHUNK/2, which always fits in $clog2(CHUNK)+2 bits.
  localparam int SW = $clog2(CHUNK) + 2;

  logic [SW-1:0] e_cnt;
  logic [SW-1:0] o_cnt;
  logic [SW-1:0] sum;

  always_comb begin
    e_cnt = '0;
    o_cnt = '0;
    for (int i = 0; i < CHUNK; i += 2) begin
      e_cnt = e_cnt + SW'(slice[i]);
      o_cnt = o_cnt + SW'(slice[i+1]);
    end
    sum = e_cnt + (o_cnt << 1);
    r_c = 2'(sum % SW'(3));
  end

endmodule

// File: rtl/div3_seq_ctrl.sv
// Sequencer for a wide divisible-by-3 check.
// Accepts one WIDTH-bit operand, walks it LSB-first one CHUNK-bit slice per
// clock through a single shared slice-residue unit, accumulates the mod-3
// residue and returns it. Stops as soon as the unconsumed bits are all zero.
// Ports:
//  clk        in   1      clock, rising edge
//  rst        in   1      synchronous active-high reset
//  in_valid   in   1      operand offered
//  in_ready   out  1      idle and able to accept
//  in_data    in   WIDTH  operand, unsigned
//  out_valid  out  1      result available
//  out_ready  in   1      consumer takes result
//  out_rem    out  2      operand mod 3
//  out_div    out  1      operand divisible by 3
//  busy       out  1      not idle
module div3_seq_ctrl
  import div3_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_rem,
  output logic             out_div,
  output logic             busy
);

  localparam int NCH = NCHUNK(WIDTH, CHUNK);
  localparam int CW  = CNT_W(NCH);

  // Every slice weight 2^(k*CHUNK) is 1 mod 3 only for even CHUNK.
  if ((WIDTH % CHUNK) != 0 || (CHUNK % 2) != 0 || CHUNK < 2) begin : g_bad_param
    $error("div3_seq_ctrl: WIDTH must be a multiple of CHUNK and CHUNK even, >= 2");
  end

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       acc;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic [1:0]       r_c;
  logic             last;

  div3_chunk_res #(.CHUNK(CHUNK)) u_chunk_res (
    .slice (shreg[CHUNK-1:0]),
    .r_c   (r_c)
  );

  // Finish on the final slice, or early once nothing nonzero remains above it.
  assign last = (cnt == CW'(NCH - 1)) || ((shreg >> CHUNK) == '0);

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign out_rem   = out_valid ? acc : 2'd0;
  assign out_div   = out_valid && (acc == 2'd0);
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= 2'd0;
      cnt   <= '0;
      shreg <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            shreg <= in_data;
            acc   <= 2'd0;
            cnt   <= '0;
          end
        end
        RUN: begin
          acc   <= mod3_add(acc, r_c);
          shreg <= shreg >> CHUNK;
          cnt   <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div3_seq_ctrl.sv
// Self-checking bench for div3_seq_ctrl (WIDTH=32, CHUNK=8).
// Expected residues/latencies are queued when an operand is offered and
// popped when the block presents a result.
module tb_div3_seq_ctrl;

  localparam int WIDTH = 32;
  localparam int CHUNK = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       out_rem;
  logic             out_div;
  logic             busy;

  typedef struct {
    logic [1:0] rem;
    int         k;
    int         acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  div3_seq_ctrl #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_rem   (out_rem),
    .out_div   (out_div),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model, independent of the slice arithmetic in the design.
  function automatic int model_k(input logic [WIDTH-1:0] d);
    int k;
    logic [CHUNK-1:0] s;
    k = 1;
    for (int i = 0; i < WIDTH / CHUNK; i++) begin
      s = d[i*CHUNK +: CHUNK];
      if (s != '0) k = i + 1;
    end
    return k;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single operand with out_ready=1: accept, measure latency, check result.
  task automatic run_op(input logic [WIDTH-1:0] d, input logic [1:0] rem,
                        input int k, input string nm);
    int   guard;
    int   lat;
    exp_t e;
    guard = 0;
    while (!in_ready && guard < 50) begin tick(); guard++; end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_accept: in_ready=%0b want 1", nm, in_ready);
      return;
    end
    in_valid = 1'b1;
    in_data  = d;
    sb.push_back('{rem, k, cyc + 1});
    tick();
    in_valid = 1'b0;
    in_data  = $urandom;
    lat = 0;
    while (!out_valid && lat < 10) begin tick(); lat++; end
    checks++;
    if (lat !== k) begin
      errors++;
      $display("FAIL %s_latency: got %0d want %0d", nm, lat, k);
    end
    if (out_valid && sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (out_rem !== e.rem) begin
        errors++;
        $display("FAIL %s_rem: got %0d want %0d", nm, out_rem, e.rem);
      end
      checks++;
      if (out_div !== (e.rem == 2'd0)) begin
        errors++;
        $display("FAIL %s_div: got %0b want %0b", nm, out_div, (e.rem == 2'd0));
      end
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_return_idle: out_valid=%0b in_ready=%0b want 0/1", nm, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    tick(); tick();
    checks++;
    if ({out_valid, busy, in_ready, out_rem, out_div} !== 6'b0) begin
      errors++;
      $display("FAIL reset_state: v=%0b busy=%0b rdy=%0b rem=%0d div=%0b want all 0",
               out_valid, busy, in_ready, out_rem, out_div);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %0b want 1", in_ready);
    end
  endtask

  task automatic test_directed();
    run_op(32'h0000_0000, 2'd0, 1, "zero");
    run_op(32'h0001_0000, 2'd1, 3, "bit16");
    run_op(32'h8000_0000, 2'd2, 4, "bit31");
    run_op(32'hFFFF_FFFF, 2'd0, 4, "all_ones");
    run_op(32'h0000_0003, 2'd0, 1, "three");
  endtask

  task automatic test_backpressure();
    int   lat;
    exp_t e;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h0000_0007;
    sb.push_back('{2'd1, 1, cyc + 1});
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 10) begin tick(); lat++; end
    e = sb.pop_front();
    checks++;
    if (lat !== e.k) begin
      errors++;
      $display("FAIL bp_latency: got %0d want %0d", lat, e.k);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_rem !== e.rem || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: v=%0b rem=%0d rdy=%0b want 1/%0d/0",
                 i, out_valid, out_rem, in_ready, e.rem);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: busy=%0b v=%0b rdy=%0b want 0/0/1", busy, out_valid, in_ready);
    end
  endtask

  task automatic test_reset_midrun();
    in_valid = 1'b1;
    in_data  = 32'hFFFF_FFFF;
    tick();                 // accept edge
    in_valid = 1'b0;
    tick();                 // now in the 2nd RUN cycle
    rst = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || dut.acc !== 2'd0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset: busy=%0b v=%0b acc=%0d rdy=%0b want 0/0/0/0",
               busy, out_valid, dut.acc, in_ready);
    end
    rst = 1'b0;
    #1;
    run_op(32'h0000_0005, 2'd2, 1, "after_reset");
  endtask

  task automatic test_back_to_back();
    localparam int N = 200;
    int got = 0;
    fork
      begin : drive
        logic [WIDTH-1:0] d;
        int  s, guard;
        logic rdy, accepted;
        for (int n = 0; n < N; n++) begin
          d = $urandom;
          s = $urandom_range(0, 4);
          if (s < 4) d = d & ((32'h1 << (8 * s)) - 32'h1);
          in_data  = d;
          in_valid = 1'b1;
          guard = 0;
          accepted = 1'b0;
          while (!accepted && guard < 100) begin
            rdy = in_ready;
            if (rdy) sb.push_back('{2'(d % 3), model_k(d), cyc + 1});
            tick();
            guard++;
            accepted = rdy;
          end
          if (!accepted) begin
            checks++;
            errors++;
            $display("FAIL b2b_accept_timeout: operand %0d not accepted", n);
            break;
          end
        end
        in_valid = 1'b0;
      end
      begin : monitor
        int   guard;
        exp_t e;
        guard = 0;
        while (got < N && guard < 5000) begin
          tick();
          guard++;
          if (out_valid) begin
            checks++;
            if (sb.size() == 0) begin
              errors++;
              $display("FAIL b2b_extra_result: rem=%0d with empty queue", out_rem);
            end else begin
              e = sb.pop_front();
              if (out_rem !== e.rem || out_div !== (e.rem == 2'd0) || (cyc - e.acc_cyc) !== e.k) begin
                errors++;
                $display("FAIL b2b_result%0d: rem=%0d div=%0b lat=%0d want %0d/%0b/%0d",
                         got, out_rem, out_div, cyc - e.acc_cyc, e.rem, (e.rem == 2'd0), e.k);
              end
            end
            got++;
          end
        end
      end
    join
    checks++;
    if (got !== N || sb.size() !== 0) begin
      errors++;
      $display("FAIL b2b_count: results=%0d pending=%0d want %0d/0", got, sb.size(), N);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midrun();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
